// File: rtl/attractor_meter.sv
// attractor_meter: measures the attractor reached by one gene-network run.
// After start it timestamps the first visit of each 8-bit state; the first
// revisit yields the cycle period, the transient length and the entry state,
// which are held on a valid/ready result port until accepted.
module attractor_meter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] init_val,
    input  logic [7:0] x,
    input  logic       x_valid,
    output logic       busy,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_init,
    output logic [8:0] res_period,
    output logic [7:0] res_transient,
    output logic [7:0] res_entry,
    output logic       res_fixed
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t state, next_state;

    logic [255:0] visited;
    logic [7:0]   first_step [0:255];
    logic [8:0]   step;

    logic         hit;          // current sample was already visited
    logic [7:0]   seen_step;    // step at which the current sample was first seen
    logic [8:0]   period_calc;  // distance back to the first visit
    logic         accept;       // a valid sample is taken in TRACK this cycle
    logic         restart;      // start honoured (IDLE or TRACK)
    logic         record;       // first visit: timestamp the state

    // Lookup of the current sample and derived control strobes.
    always_comb begin
        hit         = visited[x];
        seen_step   = first_step[x];
        period_calc = step - {1'b0, seen_step};
        restart     = start && (state != REPORT);
        accept      = (state == TRACK) && x_valid && !start;
        record      = accept && !hit;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = TRACK;
                end
            end
            TRACK: begin
                busy = 1'b1;
                // start re-enters TRACK and wins over a same-cycle sample
                if (start) begin
                    next_state = TRACK;
                end else if (x_valid && hit) begin
                    next_state = REPORT;
                end
            end
            REPORT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Visit bookkeeping, step counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            visited       <= '0;
            step          <= '0;
            res_init      <= '0;
            res_period    <= '0;
            res_transient <= '0;
            res_entry     <= '0;
            res_fixed     <= 1'b0;
        end else if (restart) begin
            visited  <= '0;
            step     <= '0;
            res_init <= init_val;
        end else if (accept) begin
            if (!hit) begin
                visited[x] <= 1'b1;
                step       <= step + 9'd1;
            end else begin
                res_period    <= period_calc;
                res_transient <= seen_step;
                res_entry     <= x;
                res_fixed     <= (period_calc == 9'd1);
            end
        end
    end

    // First-visit timestamps; entries are only read when their visited bit is set.
    always_ff @(posedge clk) begin
        if (record) begin
            first_step[x] <= step[7:0];
        end
    end

endmodule

// File: tb/tb_attractor_meter.sv
// Directed bench for attractor_meter with a result scoreboard.
module tb_attractor_meter;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] init_val;
    logic [7:0] x;
    logic       x_valid;
    logic       busy;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_init;
    logic [8:0] res_period;
    logic [7:0] res_transient;
    logic [7:0] res_entry;
    logic       res_fixed;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] init;
        logic [8:0] period;
        logic [7:0] trans;
        logic [7:0] entry;
        logic       fixed;
    } res_t;

    res_t sb[$];

    attractor_meter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .init_val      (init_val),
        .x             (x),
        .x_valid       (x_valid),
        .busy          (busy),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_init      (res_init),
        .res_period    (res_period),
        .res_transient (res_transient),
        .res_entry     (res_entry),
        .res_fixed     (res_fixed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at a falling edge, return at the next falling edge.
    task automatic cyc(input logic s, input logic xv, input logic [7:0] xx);
        start   = s;
        x_valid = xv;
        x       = xx;
        @(negedge clk);
    endtask

    task automatic do_start(input logic [7:0] iv);
        init_val = iv;
        cyc(1'b1, 1'b0, 8'h00);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic feed(input logic [7:0] v);
        cyc(1'b0, 1'b1, v);
    endtask

    task automatic expect_res(input logic [7:0] iv, input logic [8:0] p,
                              input logic [7:0] t, input logic [7:0] e);
        res_t r;
        r.init   = iv;
        r.period = p;
        r.trans  = t;
        r.entry  = e;
        r.fixed  = (p == 9'd1);
        sb.push_back(r);
    endtask

    task automatic chk_fields(input string tag, input res_t e);
        chk({tag, "_init"},   res_init, e.init);
        chk({tag, "_period"}, res_period, e.period);
        chk({tag, "_trans"},  res_transient, e.trans);
        chk({tag, "_entry"},  res_entry, e.entry);
        chk({tag, "_fixed"},  res_fixed, e.fixed);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_valid"},  res_valid, 0);
        chk({tag, "_init"},   res_init, 0);
        chk({tag, "_period"}, res_period, 0);
        chk({tag, "_trans"},  res_transient, 0);
        chk({tag, "_entry"},  res_entry, 0);
        chk({tag, "_fixed"},  res_fixed, 0);
    endtask

    // Called right after the repeating sample; result must already be valid.
    // During 'hold' stall cycles start/x_valid are pushed and must be ignored.
    task automatic get_result(input string tag, input int hold);
        res_t e;
        int   n;
        start   = 1'b0;
        x_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 0);
        chk({tag, "_valid"}, res_valid, 1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        chk_fields(tag, e);
        for (int i = 0; i < hold; i++) begin
            init_val = 8'hAA;
            cyc(1'b1, 1'b1, 8'h99);
            chk({tag, "_hold_valid"}, res_valid, 1);
            chk({tag, "_hold_busy"}, busy, 1);
            chk_fields({tag, "_hold"}, e);
        end
        start     = 1'b0;
        x_valid   = 1'b0;
        chk({tag, "_busy_hs"}, busy, 1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_valid_after_hs"}, res_valid, 0);
        chk({tag, "_busy_after_hs"}, busy, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        init_val  = 8'h00;
        x         = 8'h00;
        x_valid   = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        // x_valid in IDLE must be ignored
        feed(8'h05);
        cyc(1'b0, 1'b0, 8'h00);
        chk("idle_busy", busy, 0);
        chk("idle_valid", res_valid, 0);

        // Fixed point
        do_start(8'h05);
        feed(8'h05);
        chk("fp_no_early_valid", res_valid, 0);
        expect_res(8'h05, 9'd1, 8'd0, 8'h05);
        feed(8'h05);
        get_result("fixed", 0);

        // Transient plus 2-cycle
        do_start(8'h01);
        feed(8'h01);
        feed(8'h02);
        feed(8'h03);
        chk("tr_no_early_valid", res_valid, 0);
        expect_res(8'h01, 9'd2, 8'd1, 8'h02);
        feed(8'h02);
        get_result("trans2", 0);

        // Maximum length: full 256 cycle
        do_start(8'h00);
        for (int i = 0; i < 256; i++) feed(8'(i));
        chk("max_no_early_valid", res_valid, 0);
        expect_res(8'h00, 9'd256, 8'd0, 8'h00);
        feed(8'h00);
        get_result("max256", 0);

        // Maximum transient: 255 steps then fixed point
        do_start(8'h00);
        for (int i = 0; i < 256; i++) feed(8'(i));
        expect_res(8'h00, 9'd1, 8'd255, 8'hFF);
        feed(8'hFF);
        get_result("maxtrans", 0);

        // Gaps and backpressure; x during gaps is a would-be repeat
        do_start(8'h10);
        feed(8'h10);
        cyc(1'b0, 1'b0, 8'h10);
        feed(8'h20);
        cyc(1'b0, 1'b0, 8'h20);
        chk("gap_no_early_valid", res_valid, 0);
        expect_res(8'h10, 9'd2, 8'd0, 8'h10);
        feed(8'h10);
        get_result("gaps", 5);

        // Restart in TRACK; start wins over the same-cycle sample
        do_start(8'h11);
        feed(8'h11);
        feed(8'h22);
        init_val = 8'h22;
        cyc(1'b1, 1'b1, 8'h22);
        chk("restart_busy", busy, 1);
        chk("restart_valid", res_valid, 0);
        feed(8'h22);
        chk("restart_no_stale", res_valid, 0);
        feed(8'h33);
        expect_res(8'h22, 9'd2, 8'd0, 8'h22);
        feed(8'h22);
        get_result("restart", 0);

        // Reset during TRACK
        do_start(8'h40);
        feed(8'h40);
        feed(8'h41);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_track");
        @(negedge clk);
        rst_n = 1'b1;
        do_start(8'h01);
        feed(8'h01);
        feed(8'h02);
        feed(8'h03);
        expect_res(8'h01, 9'd2, 8'd1, 8'h02);
        feed(8'h02);
        get_result("after_rst_track", 0);

        // Reset during REPORT discards the pending result
        do_start(8'h07);
        feed(8'h07);
        feed(8'h07);
        start   = 1'b0;
        x_valid = 1'b0;
        chk("rpt_valid_before_rst", res_valid, 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_report");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rpt_idle_busy", busy, 0);
        do_start(8'h30);
        feed(8'h30);
        feed(8'h31);
        feed(8'h32);
        feed(8'h33);
        expect_res(8'h30, 9'd3, 8'd1, 8'h31);
        feed(8'h31);
        get_result("after_rst_report", 0);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/attractor_meter.md
# attractor_meter

Consumer of the gene network's state stream. After a `start` pulse it samples the 8-bit state `x` on each valid cycle and records the step at which each state is first visited. On the first revisit it reports the attractor period, the transient length and the state where the cycle was entered, over a valid/ready result handshake. The fixed-point and cycle checkers only flag that an attractor was reached; this block measures it, so one run of the network from one initial value yields the full basin/attractor figure for that value.

## Interface
- No parameters. State width is fixed at 8 bits (256 states).
- `clk`  in  1  – single clock; all state updates on the rising edge.
- `rst_n`  in  1  – asynchronous, active-low reset.
- `start`  in  1  – one-cycle pulse that begins a measurement.
- `init_val`  in  8  – initial value of the run. Captured on `start` and echoed in the result.
- `x`  in  8  – current gene-network state.
- `x_valid`  in  1  – `x` is a new network step this cycle.
- `busy`  out  1  – high in TRACK and REPORT.
- `res_valid`  out  1  – result fields are valid.
- `res_ready`  in  1  – consumer accepts the result.
- `res_init`  out  8  – captured `init_val`.
- `res_period`  out  9  – cycle length, 1..256.
- `res_transient`  out  8  – steps before entering the cycle, 0..255.
- `res_entry`  out  8  – first state of the cycle (the repeated state).
- `res_fixed`  out  1  – high when `res_period == 1`.

## Operation
- Internal storage:
  - `visited[255:0]` bit vector.
  - `first_step[0:255]`, 8 bits per entry.
  - step counter `step`, 9 bits.
- States: IDLE, TRACK, REPORT.
- **IDLE**
  - `start` clears all of `visited` in one cycle, sets `step` to 0, captures `init_val` and goes to TRACK.
  - `x_valid` is ignored in IDLE.
- **TRACK**, on each `x_valid`:
  - If `visited[x]` is 0: set `visited[x]`, write `first_step[x] = step[7:0]`, increment `step`.
  - If `visited[x]` is 1:
    - `res_period = step - first_step[x]` (9-bit, zero-extended)
    - `res_transient = first_step[x]`
    - `res_entry = x`
    - go to REPORT.
  - Cycles with `x_valid` low leave all state unchanged.
  - `start` in TRACK aborts the run and restarts it exactly as `start` in IDLE does. `start` takes priority over a same-cycle `x_valid`.
- **REPORT**
  - `res_valid` is high and all result fields are held stable.
  - `res_valid & res_ready` returns the block to IDLE.
  - `start` and `x_valid` are ignored in REPORT.
- Step 0 is the first sample taken after `start`. The driver presents `init_val` as that first sample.
- Pigeonhole guarantee: at most 256 distinct samples precede a revisit, so `step` never exceeds 256 and `first_step` never overflows.

## Timing
- Reset values: state IDLE. All outputs are 0: `busy`, `res_valid`, all `res_*` fields. `visited` is cleared.
- Async reset asserted mid-operation returns the block to IDLE immediately. Any pending result is discarded.
- The `start` edge moves the block to TRACK. The earliest `x_valid` that counts is the edge after the `start` edge.
- Detection latency: the edge that samples the repeated `x` loads the result fields and sets `res_valid`. `res_valid` is therefore visible in the cycle after the repeat was presented.
- `res_valid` stays high until the handshake edge and drops on the following cycle.
- `busy` is high from the cycle after `start` up to and including the handshake cycle.
- Throughput: one sample per cycle, no stalls. The earliest next `start` is the cycle after the handshake.

## Test plan
- **Fixed point:** `start` with `init_val=0x05`, then `x` = 0x05, 0x05 on consecutive valid cycles. Required: `res_period=1`, `res_transient=0`, `res_entry=0x05`, `res_fixed=1`, `res_init=0x05`.
- **Transient plus 2-cycle:** `x` = 0x01, 0x02, 0x03, 0x02. Required: `res_period=2`, `res_transient=1`, `res_entry=0x02`, `res_fixed=0`.
- **Maximum length:** `x` = 0x00..0xFF in order, then 0x00. Required: `res_period=256`, `res_transient=0`, `res_entry=0x00`. Then `x` = 0x00..0xFF, then 0xFF. Required: `res_period=1`, `res_transient=255`.
- **Gaps and backpressure:** `x_valid` toggles 1,0,1,0 with `x` = 0x10, 0x20, 0x10. Required: `res_period=2`, `res_transient=0`. Then hold `res_ready=0` for 5 cycles. Required: `res_valid` and all fields stable for those cycles, and a concurrent `start` is ignored.
- **Restart in TRACK:** feed 0x11, 0x22, then `start` together with `x_valid`, then 0x22, 0x33, 0x22. Required: `res_period=2`, `res_transient=0`. No stale `visited` bits survive the restart.
- **Reset mid-run:** pull `rst_n` low during TRACK and again during REPORT. Required: all outputs read 0 within the same cycle, the block is in IDLE, and a subsequent run produces correct results.
